// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default flit width, port count and port index order.
package noc_pkg;

  localparam int DEF_FLIT_W    = 16;
  localparam int DEF_NUM_PORTS = 5;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

endpackage

// File: rtl/flit_fifo.sv
// Single-channel first-word-fall-through flit FIFO with occupancy, credit return
// and sticky overflow/underflow flags.
module flit_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              pop_i,
  output logic [FLIT_W-1:0] data_o,
  output logic              valid_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              credit_o,
  output logic              ovf_o,
  output logic              udf_o
);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              credit_q;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_acc;
  logic              pop_acc;

  assign valid_o  = (count_q != '0);
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign count_o  = count_q;
  assign credit_o = credit_q;
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;
  assign data_o   = valid_o ? mem_q[rptr_q] : '0;

  // A pop frees a slot in the same cycle, so a full channel still takes a push alongside it.
  assign push_acc = push_i & (~full_o | pop_i);
  assign pop_acc  = pop_i & valid_o;

  always_comb begin
    wptr_d  = push_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_acc  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push_i & full_o & ~pop_i);
    udf_d = udf_q | (pop_i & ~valid_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      credit_q <= pop_acc;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left unreset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/router_input_fifo_bank.sv
// Bank of independent per-port input FIFOs between the link receivers and
// route-compute/arbitration; only instantiation and port slicing live here.
module router_input_fifo_bank
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int FLIT_W    = DEF_FLIT_W,
  parameter int DEPTH     = 4,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        push_i,
  input  logic [NUM_PORTS*FLIT_W-1:0] data_i,
  input  logic [NUM_PORTS-1:0]        pop_i,
  output logic [NUM_PORTS*FLIT_W-1:0] data_o,
  output logic [NUM_PORTS-1:0]        valid_o,
  output logic [NUM_PORTS-1:0]        full_o,
  output logic [NUM_PORTS*CNT_W-1:0]  count_o,
  output logic [NUM_PORTS-1:0]        credit_o,
  output logic [NUM_PORTS-1:0]        ovf_o,
  output logic [NUM_PORTS-1:0]        udf_o
);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_ch
    flit_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (push_i[k]),
      .data_i   (data_i[k*FLIT_W +: FLIT_W]),
      .pop_i    (pop_i[k]),
      .data_o   (data_o[k*FLIT_W +: FLIT_W]),
      .valid_o  (valid_o[k]),
      .full_o   (full_o[k]),
      .count_o  (count_o[k*CNT_W +: CNT_W]),
      .credit_o (credit_o[k]),
      .ovf_o    (ovf_o[k]),
      .udf_o    (udf_o[k])
    );
  end

endmodule

// File: tb/tb_router_input_fifo_bank.sv
// Scoreboard bench for router_input_fifo_bank: directed vectors, queue model checked every cycle.
module tb_router_input_fifo_bank;

  localparam int NP = 5;
  localparam int FW = 16;
  localparam int DP = 4;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    push_i;
  logic [NP*FW-1:0] data_i;
  logic [NP-1:0]    pop_i;
  logic [NP*FW-1:0] data_o;
  logic [NP-1:0]    valid_o;
  logic [NP-1:0]    full_o;
  logic [NP*CW-1:0] count_o;
  logic [NP-1:0]    credit_o;
  logic [NP-1:0]    ovf_o;
  logic [NP-1:0]    udf_o;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] exp_q [NP][$];
  logic [NP-1:0] exp_cred = '0;
  logic [NP-1:0] exp_ovf  = '0;
  logic [NP-1:0] exp_udf  = '0;

  router_input_fifo_bank #(.NUM_PORTS(NP), .FLIT_W(FW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_i),
    .data_i   (data_i),
    .pop_i    (pop_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .full_o   (full_o),
    .count_o  (count_o),
    .credit_o (credit_o),
    .ovf_o    (ovf_o),
    .udf_o    (udf_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare outputs against the queue model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    for (int k = 0; k < NP; k++) begin
      int n;
      logic pa, wa;
      n = exp_q[k].size();
      chk($sformatf("ch%0d valid", k), 32'(valid_o[k]), 32'(n != 0));
      chk($sformatf("ch%0d full", k), 32'(full_o[k]), 32'(n == DP));
      chk($sformatf("ch%0d count", k), 32'(count_o[k*CW +: CW]), 32'(n));
      chk($sformatf("ch%0d head", k), 32'(data_o[k*FW +: FW]), (n != 0) ? 32'(exp_q[k][0]) : 32'd0);
      chk($sformatf("ch%0d credit", k), 32'(credit_o[k]), 32'(exp_cred[k]));
      chk($sformatf("ch%0d ovf", k), 32'(ovf_o[k]), 32'(exp_ovf[k]));
      chk($sformatf("ch%0d udf", k), 32'(udf_o[k]), 32'(exp_udf[k]));
      if (rst === 1'b1) begin
        exp_q[k].delete();
        exp_cred[k] = 1'b0;
        exp_ovf[k]  = 1'b0;
        exp_udf[k]  = 1'b0;
      end else begin
        pa = pop_i[k] && (n > 0);
        wa = push_i[k] && ((n < DP) || pop_i[k]);
        if (push_i[k] && (n == DP) && !pop_i[k]) exp_ovf[k] = 1'b1;
        if (pop_i[k] && (n == 0)) exp_udf[k] = 1'b1;
        if (pa) void'(exp_q[k].pop_front());
        if (wa) exp_q[k].push_back(data_i[k*FW +: FW]);
        exp_cred[k] = pa;
      end
    end
  end

  task automatic set_d(input int k, input logic [FW-1:0] v);
    data_i[k*FW +: FW] = v;
  endtask

  task automatic step(input logic [NP-1:0] ps, input logic [NP-1:0] pp, input logic r);
    push_i = ps;
    pop_i  = pp;
    rst    = r;
    @(posedge clk);
    #1;
    push_i = '0;
    pop_i  = '0;
    rst    = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt(input int k);
    return count_o[k*CW +: CW];
  endfunction

  function automatic logic [FW-1:0] dout(input int k);
    return data_o[k*FW +: FW];
  endfunction

  initial begin
    push_i = '0;
    pop_i  = '0;
    data_i = '0;
    rst    = 1'b1;
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset count", 32'(count_o), 32'd0);
    chk("reset data", 32'(data_o[31:0]), 32'd0);
    chk("reset flags", 32'({credit_o, ovf_o, udf_o, full_o}), 32'd0);

    // Channel 2: fill, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      set_d(2, 16'hA000 + 16'(i));
      step(5'b00100, '0, 1'b0);
    end
    chk("ch2 full after 4", 32'(full_o[2]), 32'd1);
    chk("ch2 count after 4", 32'(cnt(2)), 32'd4);
    chk("ch2 head A001", 32'(dout(2)), 32'hA001);
    for (int i = 0; i < 4; i++) begin
      step('0, 5'b00100, 1'b0);
      chk("ch2 credit after pop", 32'(credit_o[2]), 32'd1);
    end
    step('0, '0, 1'b0);
    chk("ch2 credit idle", 32'(credit_o[2]), 32'd0);
    chk("ch2 empty", 32'(valid_o[2]), 32'd0);

    // Channel 0: overflow drop, then push alongside pop on full.
    for (int i = 0; i < 4; i++) begin
      set_d(0, 16'hC000 + 16'(i));
      step(5'b00001, '0, 1'b0);
    end
    set_d(0, 16'hBEEF);
    step(5'b00001, '0, 1'b0);
    chk("ch0 ovf", 32'(ovf_o[0]), 32'd1);
    chk("ch0 count after drop", 32'(cnt(0)), 32'd4);
    chk("ch0 head after drop", 32'(dout(0)), 32'hC000);
    step(5'b00001, 5'b00001, 1'b0);
    chk("ch0 count push+pop full", 32'(cnt(0)), 32'd4);
    for (int i = 0; i < 3; i++) step('0, 5'b00001, 1'b0);
    chk("ch0 last is BEEF", 32'(dout(0)), 32'hBEEF);
    step('0, 5'b00001, 1'b0);
    chk("ch0 drained", 32'(cnt(0)), 32'd0);
    chk("ch0 ovf sticky", 32'(ovf_o[0]), 32'd1);

    // Channel 4: pop on empty.
    step('0, 5'b10000, 1'b0);
    chk("ch4 udf", 32'(udf_o[4]), 32'd1);
    chk("ch4 count", 32'(cnt(4)), 32'd0);
    chk("ch4 no credit", 32'(credit_o[4]), 32'd0);
    chk("ch4 data zero", 32'(dout(4)), 32'd0);

    // Channel 1: steady push+pop at occupancy 1, crossing pointer wrap.
    set_d(1, 16'hD000);
    step(5'b00010, '0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      set_d(1, 16'hD000 + 16'(i));
      step(5'b00010, 5'b00010, 1'b0);
      chk("ch1 count stays 1", 32'(cnt(1)), 32'd1);
      chk("ch1 head order", 32'(dout(1)), 32'(16'hD000 + 16'(i)));
    end
    step('0, 5'b00010, 1'b0);
    chk("ch1 drained", 32'(valid_o[1]), 32'd0);

    // All channels push distinct flits in one cycle.
    for (int k = 0; k < NP; k++) set_d(k, 16'hE000 + 16'(k * 16'h11));
    step(5'b11111, '0, 1'b0);
    for (int k = 0; k < NP; k++)
      chk($sformatf("ch%0d own flit", k), 32'(dout(k)), 32'(16'hE000 + 16'(k * 16'h11)));

    // Reset mid-operation with 3 flits queued on channel 3 and pops pending.
    set_d(3, 16'hF001);
    step(5'b01000, '0, 1'b0);
    set_d(3, 16'hF002);
    step(5'b01000, '0, 1'b0);
    chk("ch3 count 3", 32'(cnt(3)), 32'd3);
    step('0, 5'b11111, 1'b1);
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst count", 32'(count_o), 32'd0);
    chk("rst credit", 32'(credit_o), 32'd0);
    chk("rst ovf udf", 32'({ovf_o, udf_o}), 32'd0);
    chk("rst data", 32'(data_o[79:48]), 32'd0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
